cv32e40p_nmr_voter_monitor: RTL and testbench
=============================================

Name: cv32e40p_nmr_voter_monitor

Overview:
Parametrised N-modular-redundancy voter with built-in per-replica health tracking. It is the successor to the fixed triple voter plus breakage-monitor pairing in the fault-tolerant wrappers. It receives N replica copies of a W-bit result, masks replicas declared broken, and produces a registered majority output with detected/corrected status. Each replica has a leaky-bucket error counter and a health FSM; a broken replica can be re-admitted through a probation phase.

Parameters:
N, 3, replica count; odd, 3..7
W, 32, data width per replica
INCREMENT, 4, counter add on a replica mismatch
DECREMENT, 1, counter subtract on a clean valid cycle
BREAKING_THRESHOLD, 16, counter value at or above which the replica goes BROKEN
COUNT_BIT, 6, counter width; must hold BREAKING_THRESHOLD+INCREMENT
PROBATION_CYCLES, 8, consecutive clean valid cycles needed to leave PROBATION

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
valid_i  in  1  replica data valid this cycle
to_vote_i  in  N*W  replica i occupies bits [i*W +: W]
set_broken_i  in  N  force replica BROKEN (level, sampled each cycle)
clr_broken_i  in  N  request BROKEN->PROBATION (level)
voted_o  out  W  registered voted result
valid_o  out  1  voted_o valid
err_detected_o  out  1  some active replica disagreed with voted_o
err_corrected_o  out  1  disagreement masked by a strict majority
uncorrectable_o  out  1  no strict majority on at least one bit, or no active replica
is_broken_o  out  N  replica i in BROKEN or PROBATION
health_state_o  out  2*N  per-replica FSM state: 0 HEALTHY, 1 SUSPECT, 2 BROKEN, 3 PROBATION

Behaviour:
- Active set: replicas in HEALTHY or SUSPECT. Only active replicas vote. PROBATION replicas are compared but do not vote.
- Per-bit majority over the active set; a 1 needs strictly more than half of the active count.
- Per-bit tie (even active count): output the lowest-index active replica's bit and assert uncorrectable_o.
- Active count 1: pass-through of that replica, no error flags.
- Active count 0: voted_o=0, uncorrectable_o=1.
- Latency: 1 cycle. voted_o, valid_o and all flags register on the clk edge after valid_i.
- When valid_i=0: valid_o=0, flags=0, voted_o holds its last value.
- err_detected_o = any active replica != combinational vote.
- err_corrected_o = err_detected_o & ~uncorrectable_o.
- Counters update only when valid_i=1:
  - replica mismatch -> +INCREMENT, saturating at 2^COUNT_BIT-1;
  - match -> -DECREMENT, floor 0.
  - A mismatch is evaluated for active and PROBATION replicas only.
- FSM per replica, next state applied on the same edge as the counter update:
  - HEALTHY -> SUSPECT when the counter becomes nonzero.
  - SUSPECT -> HEALTHY when the counter returns to 0.
  - SUSPECT/HEALTHY -> BROKEN when the counter is >= BREAKING_THRESHOLD.
  - BROKEN -> PROBATION on clr_broken_i; counter and probation count cleared.
  - PROBATION -> HEALTHY after PROBATION_CYCLES consecutive clean valid cycles.
  - PROBATION -> BROKEN on any mismatch.
  - BROKEN: counter frozen.
- set_broken_i forces BROKEN from any state next cycle and has priority over clr_broken_i and counter activity.
- Simultaneous mismatch events on several replicas are each processed independently in the same cycle.
- Health decisions take effect for voting on the cycle after the state change, never combinationally.
- Reset (rst=1 at an edge): all replicas HEALTHY, counters and probation counts 0, voted_o=0, valid_o=0, all flags 0, is_broken_o=0. Reset in mid-probation discards progress.

Optional Feature:
Macro FT_NMR_ERR_STATS_EN.
- Defined:
  - adds input stats_clr_i (1) and output corr_count_o (32);
  - corr_count_o increments by 1 on every cycle where err_corrected_o is registered to 1, saturating at 0xFFFFFFFF;
  - stats_clr_i synchronously clears it, and clear wins over increment;
  - rst clears it to 0.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- N=3, W=32, all replicas equal 0xA5A5A5A5 with valid_i=1 -> one cycle later voted_o=0xA5A5A5A5, valid_o=1, all flags 0, states all HEALTHY.
- Replica 1 = 0x00000000, others 0xDEADBEEF, for 4 valid cycles -> voted_o=0xDEADBEEF, err_corrected_o=1 each cycle; replica 1 counter 4,8,12,16; BROKEN after the 4th cycle; next cycle flags 0 and uncorrectable_o=0.
- Replica 1 BROKEN, replicas 0/2 disagree (0x1 vs 0x3) -> voted_o=0x1 (lowest-index tie rule), uncorrectable_o=1, err_corrected_o=0.
- Pulse clr_broken_i[1] with replica 1 matching for 8 valid cycles -> state 3 for 8 cycles, then 0; a single mismatch at cycle 5 -> back to state 2.
- set_broken_i=3'b011 held with clr_broken_i[0]=1 -> replicas 0,1 BROKEN; replica 2 passes through, no flags; all-broken case gives voted_o=0, uncorrectable_o=1.
- rst asserted mid-probation -> next cycle all outputs 0, states HEALTHY; with FT_NMR_ERR_STATS_EN, 5 corrected cycles then stats_clr_i -> corr_count_o 5 then 0.

Source files
------------

// File: rtl/cv32e40p_nmr_voter_monitor.sv
// cv32e40p_nmr_voter_monitor: N-modular voter with per-replica leaky-bucket health FSMs; FT_NMR_ERR_STATS_EN adds a corrected-error counter
module cv32e40p_nmr_voter_monitor #(
  parameter int N = 3,
  parameter int W = 32,
  parameter int INCREMENT = 4,
  parameter int DECREMENT = 1,
  parameter int BREAKING_THRESHOLD = 16,
  parameter int COUNT_BIT = 6,
  parameter int PROBATION_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  input  logic [N*W-1:0] to_vote_i,
  input  logic [N-1:0]   set_broken_i,
  input  logic [N-1:0]   clr_broken_i,
`ifdef FT_NMR_ERR_STATS_EN
  input  logic           stats_clr_i,
  output logic [31:0]    corr_count_o,
`endif
  output logic [W-1:0]   voted_o,
  output logic           valid_o,
  output logic           err_detected_o,
  output logic           err_corrected_o,
  output logic           uncorrectable_o,
  output logic [N-1:0]   is_broken_o,
  output logic [2*N-1:0] health_state_o
);
  localparam int PW = $clog2(PROBATION_CYCLES + 1);
  localparam int CW = $clog2(N + 1);
  localparam logic [COUNT_BIT:0]   INC_W = (COUNT_BIT + 1)'(INCREMENT);
  localparam logic [COUNT_BIT-1:0] DEC_C = COUNT_BIT'(DECREMENT);
  localparam logic [COUNT_BIT-1:0] THR_C = COUNT_BIT'(BREAKING_THRESHOLD);
  localparam logic [COUNT_BIT-1:0] MAX_C = '1;
  localparam logic [PW-1:0]        PROB_LAST = PW'(PROBATION_CYCLES - 1);
  typedef enum logic [1:0] {HEALTHY = 2'd0, SUSPECT = 2'd1, BROKEN = 2'd2, PROBATION = 2'd3} health_e;
  health_e              st_q [N];
  health_e              st_d [N];
  logic [COUNT_BIT-1:0] cnt_q [N];
  logic [COUNT_BIT-1:0] cnt_d [N];
  logic [COUNT_BIT-1:0] cnt_upd [N];
  logic [COUNT_BIT:0]   sum [N];
  logic [PW-1:0]        prob_q [N];
  logic [PW-1:0]        prob_d [N];
  logic [N-1:0]         act, mm;
  logic [CW-1:0]        act_cnt, ones;
  logic                 first, found, tie_any, det;
  logic [W-1:0]         vote, voted_q, voted_d;
  logic                 valid_q, valid_d, det_q, det_d, corr_q, corr_d, unc_q, unc_d;
  always_comb begin
    act = '0;
    act_cnt = '0;
    for (int i = 0; i < N; i++) begin
      act[i] = !st_q[i][1];
      act_cnt = act_cnt + CW'(act[i]);
    end
    vote = '0;
    tie_any = 1'b0;
    ones = '0;
    first = 1'b0;
    found = 1'b0;
    for (int b = 0; b < W; b++) begin
      ones = '0;
      first = 1'b0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        ones = ones + CW'(act[i] & to_vote_i[i*W+b]);
        first = (act[i] && !found) ? to_vote_i[i*W+b] : first;
        found = found | act[i];
      end
      vote[b] = (ones > act_cnt - ones) ? 1'b1 : (ones < act_cnt - ones) ? 1'b0 : first;
      tie_any = tie_any | (ones == act_cnt - ones);
    end
    mm = '0;
    for (int i = 0; i < N; i++) mm[i] = to_vote_i[i*W +: W] != vote;
    det = |(mm & act);
  end
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sum[i] = {1'b0, cnt_q[i]} + INC_W;
      cnt_upd[i] = mm[i] ? (sum[i] > {1'b0, MAX_C} ? MAX_C : sum[i][COUNT_BIT-1:0])
                         : (cnt_q[i] > DEC_C ? cnt_q[i] - DEC_C : '0);
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i];
      prob_d[i] = prob_q[i];
      if (set_broken_i[i]) st_d[i] = BROKEN;
      else if (st_q[i] == BROKEN) begin
        if (clr_broken_i[i]) begin
          st_d[i] = PROBATION;
          cnt_d[i] = '0;
          prob_d[i] = '0;
        end
      end else if (valid_i) begin
        cnt_d[i] = cnt_upd[i];
        if (st_q[i] == PROBATION) begin
          prob_d[i] = prob_q[i] + PW'(1);
          st_d[i] = mm[i] ? BROKEN : (prob_q[i] == PROB_LAST) ? HEALTHY : PROBATION;
        end else
          st_d[i] = cnt_upd[i] >= THR_C ? BROKEN : cnt_upd[i] != '0 ? SUSPECT : HEALTHY;
      end
    end
  end
  always_comb begin
    valid_d = valid_i;
    voted_d = valid_i ? vote : voted_q;
    det_d = valid_i & det;
    unc_d = valid_i & tie_any;
    corr_d = det_d & ~unc_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        st_q[i] <= HEALTHY;
        cnt_q[i] <= '0;
        prob_q[i] <= '0;
      end
      voted_q <= '0;
      valid_q <= 1'b0;
      det_q <= 1'b0;
      corr_q <= 1'b0;
      unc_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        st_q[i] <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        prob_q[i] <= prob_d[i];
      end
      voted_q <= voted_d;
      valid_q <= valid_d;
      det_q <= det_d;
      corr_q <= corr_d;
      unc_q <= unc_d;
    end
  end
`ifdef FT_NMR_ERR_STATS_EN
  logic [31:0] cc_q, cc_d;
  always_comb cc_d = stats_clr_i ? '0 : (corr_d && cc_q != '1) ? cc_q + 32'd1 : cc_q;
  always_ff @(posedge clk) cc_q <= rst ? '0 : cc_d;
  assign corr_count_o = cc_q;
`endif
  always_comb begin
    health_state_o = '0;
    is_broken_o = '0;
    for (int i = 0; i < N; i++) begin
      health_state_o[2*i +: 2] = st_q[i];
      is_broken_o[i] = st_q[i][1];
    end
  end
  assign voted_o = voted_q;
  assign valid_o = valid_q;
  assign err_detected_o = det_q;
  assign err_corrected_o = corr_q;
  assign uncorrectable_o = unc_q;
endmodule

// File: tb/tb_cv32e40p_nmr_voter_monitor.sv
// tb_cv32e40p_nmr_voter_monitor: directed vectors checked against a behavioural voter/health model
module tb_cv32e40p_nmr_voter_monitor;
  localparam int N = 3;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, valid_i;
  logic [N*W-1:0] to_vote_i;
  logic [N-1:0] set_broken_i, clr_broken_i;
  logic [W-1:0] voted_o;
  logic valid_o, err_detected_o, err_corrected_o, uncorrectable_o;
  logic [N-1:0] is_broken_o;
  logic [2*N-1:0] health_state_o;
`ifdef FT_NMR_ERR_STATS_EN
  logic stats_clr_i;
  logic [31:0] corr_count_o;
  longint m_cc;
`endif
  int n_chk = 0;
  int n_pass = 0;
  int mst [N];
  int mcnt [N];
  int mpc [N];
  logic [W-1:0] e_voted;
  logic e_valid, e_det, e_corr, e_unc;
  always #5 clk = ~clk;
  cv32e40p_nmr_voter_monitor dut (
    .clk(clk),
    .rst(rst),
    .valid_i(valid_i),
    .to_vote_i(to_vote_i),
    .set_broken_i(set_broken_i),
    .clr_broken_i(clr_broken_i),
`ifdef FT_NMR_ERR_STATS_EN
    .stats_clr_i(stats_clr_i),
    .corr_count_o(corr_count_o),
`endif
    .voted_o(voted_o),
    .valid_o(valid_o),
    .err_detected_o(err_detected_o),
    .err_corrected_o(err_corrected_o),
    .uncorrectable_o(uncorrectable_o),
    .is_broken_o(is_broken_o),
    .health_state_o(health_state_o)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [N-1:0] sb = '0, input logic [N-1:0] cb = '0);
    valid_i = v;
    to_vote_i = {c, b, a};
    set_broken_i = sb;
    clr_broken_i = cb;
    @(negedge clk);
  endtask
  always @(posedge clk) begin : mdl
    int k, ones, lo;
    logic [W-1:0] v;
    logic unc, det, mm;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mst[i] = 0;
        mcnt[i] = 0;
        mpc[i] = 0;
      end
      e_voted = '0;
      e_valid = 1'b0;
      e_det = 1'b0;
      e_corr = 1'b0;
      e_unc = 1'b0;
`ifdef FT_NMR_ERR_STATS_EN
      m_cc = 0;
`endif
    end else begin
      k = 0;
      lo = -1;
      unc = 1'b0;
      v = '0;
      for (int i = 0; i < N; i++)
        if (mst[i] < 2) begin
          k++;
          if (lo < 0) lo = i;
        end
      if (k == 0) unc = 1'b1;
      else
        for (int b = 0; b < W; b++) begin
          ones = 0;
          for (int i = 0; i < N; i++) if (mst[i] < 2 && to_vote_i[i*W+b]) ones++;
          if (2 * ones > k) v[b] = 1'b1;
          else if (2 * ones == k) begin
            v[b] = to_vote_i[lo*W+b];
            unc = 1'b1;
          end
        end
      det = 1'b0;
      for (int i = 0; i < N; i++) if (mst[i] < 2 && to_vote_i[i*W +: W] != v) det = 1'b1;
      for (int i = 0; i < N; i++) begin
        mm = mst[i] != 2 && to_vote_i[i*W +: W] != v;
        if (set_broken_i[i]) mst[i] = 2;
        else if (mst[i] == 2) begin
          if (clr_broken_i[i]) begin
            mst[i] = 3;
            mcnt[i] = 0;
            mpc[i] = 0;
          end
        end else if (valid_i) begin
          mcnt[i] = mm ? ((mcnt[i] + 4 > 63) ? 63 : mcnt[i] + 4) : (mcnt[i] > 0 ? mcnt[i] - 1 : 0);
          if (mst[i] == 3) begin
            if (mm) mst[i] = 2;
            else begin
              mpc[i]++;
              if (mpc[i] == 8) mst[i] = 0;
            end
          end else mst[i] = mcnt[i] >= 16 ? 2 : mcnt[i] > 0 ? 1 : 0;
        end
      end
      e_valid = valid_i;
      e_det = valid_i && det;
      e_unc = valid_i && unc;
      e_corr = e_det && !e_unc;
      if (valid_i) e_voted = v;
`ifdef FT_NMR_ERR_STATS_EN
      if (stats_clr_i) m_cc = 0;
      else if (e_corr && m_cc < 64'hFFFFFFFF) m_cc++;
`endif
    end
  end
  always @(negedge clk) begin : cmp
    logic [2*N-1:0] eh;
    logic [N-1:0] eb;
    for (int i = 0; i < N; i++) begin
      eh[2*i +: 2] = 2'(mst[i]);
      eb[i] = mst[i] >= 2;
    end
    chk("m_voted", voted_o, e_voted);
    chk("m_valid", valid_o, e_valid);
    chk("m_det", err_detected_o, e_det);
    chk("m_corr", err_corrected_o, e_corr);
    chk("m_unc", uncorrectable_o, e_unc);
    chk("m_health", health_state_o, eh);
    chk("m_broken", is_broken_o, eb);
`ifdef FT_NMR_ERR_STATS_EN
    chk("m_cc", corr_count_o, m_cc);
`endif
  end
  initial begin
    rst = 1'b1;
    valid_i = 1'b0;
    to_vote_i = '0;
    set_broken_i = '0;
    clr_broken_i = '0;
`ifdef FT_NMR_ERR_STATS_EN
    stats_clr_i = 1'b0;
`endif
    @(negedge clk);
    chk("rst_voted", voted_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_health", health_state_o, 0);
    chk("rst_broken", is_broken_o, 0);
    rst = 1'b0;
    step(1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    chk("eq_voted", voted_o, 32'hA5A5A5A5);
    chk("eq_valid", valid_o, 1);
    chk("eq_flags", {err_detected_o, err_corrected_o, uncorrectable_o}, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
      chk("maj_voted", voted_o, 32'hDEADBEEF);
      chk("maj_corr", err_corrected_o, 1);
      chk("maj_r1_state", health_state_o[3:2], i < 3 ? 1 : 2);
    end
    step(1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    chk("masked_voted", voted_o, 32'hDEADBEEF);
    chk("masked_flags", {err_detected_o, err_corrected_o, uncorrectable_o}, 0);
    chk("masked_broken", is_broken_o, 3'b010);
    step(1, 32'h1, 32'h55, 32'h3);
    chk("tie_voted", voted_o, 32'h1);
    chk("tie_unc", uncorrectable_o, 1);
    chk("tie_corr", err_corrected_o, 0);
    chk("tie_health", health_state_o, 6'b011000);
    step(0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b010);
    chk("idle_voted", voted_o, 32'h1);
    chk("idle_flags", {valid_o, err_detected_o, err_corrected_o, uncorrectable_o}, 0);
    chk("clr_r1_state", health_state_o[3:2], 3);
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h77, 32'h77, 32'h77);
      chk("prob_r1_state", health_state_o[3:2], i < 7 ? 3 : 0);
    end
    step(0, 32'h0, 32'h0, 32'h0, 3'b010);
    chk("set_r1_state", health_state_o[3:2], 2);
    step(0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b010);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h77, 32'h77, 32'h77);
      chk("prob2_r1_state", health_state_o[3:2], 3);
    end
    step(1, 32'h77, 32'h78, 32'h77);
    chk("prob_fail_state", health_state_o[3:2], 2);
    chk("prob_fail_flags", {err_detected_o, uncorrectable_o}, 0);
    for (int i = 0; i < 2; i++) step(1, 32'h1, 32'h2, 32'h99, 3'b011, 3'b001);
    chk("pass_voted", voted_o, 32'h99);
    chk("pass_flags", {err_detected_o, err_corrected_o, uncorrectable_o}, 0);
    chk("pass_broken", is_broken_o, 3'b011);
    for (int i = 0; i < 2; i++) step(1, 32'h1, 32'h2, 32'h99, 3'b111);
    chk("none_voted", voted_o, 0);
    chk("none_unc", uncorrectable_o, 1);
    chk("none_det", err_detected_o, 0);
    step(0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b111);
    chk("allprob_health", health_state_o, 6'b111111);
    step(1, 32'h5, 32'h5, 32'h5);
    step(1, 32'h5, 32'h5, 32'h5);
    rst = 1'b1;
    step(1, 32'h5, 32'h5, 32'h5);
    chk("mrst_out", {voted_o, valid_o, err_detected_o, err_corrected_o, uncorrectable_o}, 0);
    chk("mrst_health", health_state_o, 0);
    chk("mrst_broken", is_broken_o, 0);
    rst = 1'b0;
    step(1, 32'h5, 32'h5, 32'h5);
    chk("post_rst_voted", voted_o, 32'h5);
    for (int i = 0; i < 5; i++) begin
      step(1, (i % 3 == 0) ? 32'h11 : 32'h10, (i % 3 == 1) ? 32'h11 : 32'h10, (i % 3 == 2) ? 32'h11 : 32'h10);
      chk("cnt_corr", err_corrected_o, 1);
    end
`ifdef FT_NMR_ERR_STATS_EN
    chk("stats_five", corr_count_o, 5);
    stats_clr_i = 1'b1;
    step(1, 32'h10, 32'h11, 32'h10);
    stats_clr_i = 1'b0;
    chk("stats_clr", corr_count_o, 0);
`endif
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
